adder_accum_12bit: RTL
======================

# adder_accum_12bit

Sequential accumulation stage directly downstream of the 12-bit carry-skip adder datapath. It accepts a stream of 12-bit operands over a valid/ready handshake and adds each one into a running accumulator through an internal 3×4-bit carry-skip adder. A sticky overflow flag tracks the adder's carry-out. On the operand flagged last, it presents the total, the overflow flag and the operand count on a valid/ready output port.

## Interface
- WIDTH, 12, operand/accumulator width; must be a multiple of BLOCK.
- BLOCK, 4, carry-skip block width.
- CNT_W, 8, operand-count width.

- i_clk  in  1  rising-edge clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_clear  in  1  synchronous abort/clear; highest priority after reset.
- i_in_valid  in  1  operand valid.
- o_in_ready  out  1  operand accepted when high with i_in_valid.
- i_operand  in  WIDTH  operand.
- i_last  in  1  marks final operand of a group; qualified by the input handshake.
- o_out_valid  out  1  result valid.
- i_out_ready  in  1  result consumed when high with o_out_valid.
- o_sum  out  WIDTH  accumulated total, modulo 2^WIDTH.
- o_ovf  out  1  sticky: any addition in the group produced carry-out.
- o_nops  out  CNT_W  operands in the group; saturates at 2^CNT_W−1.
- o_skip_hits  out  CNT_W  present only with ADDER_ACCUM_SKIP_STATS_EN; see Configuration.

## Operation
- Two states: ACCUM and HOLD. Reset state is ACCUM.
- **ACCUM**
  - o_in_ready=1, o_out_valid=0.
  - On handshake: acc ← acc + i_operand (adder carry-in 0); ovf ← ovf | cout; nops ← sat(nops+1).
  - If i_last is high on the handshake, go to HOLD. The registered values already include that operand.
- **HOLD**
  - o_in_ready=0, o_out_valid=1.
  - o_sum, o_ovf and o_nops are stable while waiting.
  - On output handshake: acc, ovf and nops ← 0, and the state returns to ACCUM.
  - i_in_valid is ignored in HOLD.
- **i_clear** (either state): acc, ovf, nops and skip_hits ← 0; state ← ACCUM. Any operand or output handshake in the same cycle is discarded.
- Group of one operand with i_last set: result = operand, nops=1.
- Wrap-around: the sum is truncated to WIDTH; the carry only sets ovf.
- Output signals o_sum, o_ovf and o_nops come directly from registers: acc, ovf and nops.

## Timing
- Reset values: o_in_ready=1 (ACCUM), o_out_valid=0, o_sum=0, o_ovf=0, o_nops=0, o_skip_hits=0.
- Reset is asynchronous mid-operation. It aborts any group in progress, including in HOLD with a result pending.
- Accumulate throughput: one operand per cycle. The adder is a single-cycle combinational path, register to register.
- Latency: last operand accepted at edge N gives o_out_valid high after edge N. The result is visible in cycle N+1.
- Output handshake at edge M gives o_in_ready high in cycle M+1. The minimum bubble between groups is one cycle.
- o_in_ready depends only on state. There is no combinational path from i_out_ready to o_in_ready.

## Configuration
- Macro: ADDER_ACCUM_SKIP_STATS_EN.
- **Defined:**
  - Port o_skip_hits exists.
  - Counts accepted operands for which at least one BLOCK-wide segment of acc ^ i_operand is all ones, i.e. the skip path was taken.
  - The counter saturates and is cleared with the group (output handshake, i_clear or reset).
- **Undefined:** the port and counter are absent. There is no other behavioural difference.

## Structure
- Shared package adder_pkg:
  - WIDTH/BLOCK/CNT_W default constants.
  - Block-count constant NBLK = WIDTH/BLOCK.
  - State enum acc_state_e {ACCUM, HOLD}.
- Sub-module cskip_core: combinational WIDTH-bit carry-skip adder.
  - Ports a, b, cin, sum, cout, blk_prop[NBLK-1:0].
  - Ripple within each block; block carry is skipped when the block propagate is all ones.
  - blk_prop feeds the skip statistics.
- The top level holds the FSM, registers and saturating counters.

## Test plan
- Operands 0x123, 0x456, 0x789 (last) back-to-back, i_out_ready=1 → o_sum=0xD02, o_ovf=0, o_nops=3, o_out_valid for 1 cycle.
- Operands 0xFFF, 0x001 (last) → o_sum=0x000, o_ovf=1, o_nops=2. The next group 0x005 (last) → o_sum=0x005, o_ovf=0.
- HOLD with i_out_ready=0 for 5 cycles and i_in_valid=1 throughout → o_in_ready=0, outputs stable, no operand accepted. Release → next operand accepted in the following cycle.
- Operands 0x010, 0x020, then i_clear, then 0x007 (last) → o_sum=0x007, o_nops=1.
- With macro: 0x000+0xFFF, then 0x0F0 (last) → o_skip_hits=2 (0xFFF^0x000 all blocks propagate; 0xFFF^0x0F0=0xF0F). Without macro, o_sum=0x0EF and ovf=1.
- Assert i_rst_n low for one cycle while in HOLD → all outputs at reset values immediately, o_in_ready=1 after release.

Source files
------------

// File: rtl/adder_pkg.sv
// ============================================================================
// Module      : adder_pkg
// Description : Shared constants and types for the 12-bit accumulation stage
//               and its carry-skip adder core.
//               c_WIDTH  - operand/accumulator width (multiple of c_BLOCK)
//               c_BLOCK  - carry-skip block width
//               c_CNT_W  - operand / skip-hit counter width
//               c_NBLK   - number of carry-skip blocks
//               acc_state_e - accumulator FSM states
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_pkg;

    localparam int c_WIDTH = 12;
    localparam int c_BLOCK = 4;
    localparam int c_CNT_W = 8;
    localparam int c_NBLK  = c_WIDTH / c_BLOCK;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

endpackage

`default_nettype wire

// File: rtl/adder_accum_12bit_if.sv
// ============================================================================
// Module      : adder_accum_12bit_if
// Description : Operand-in / result-out handshake bundle for adder_accum_12bit.
//               Signal directions are named from the accumulator's view.
//               i_in_valid/o_in_ready/i_operand/i_last - operand stream
//               o_out_valid/i_out_ready               - result handshake
//               o_sum/o_ovf/o_nops                    - group result
//               o_skip_hits - only with ADDER_ACCUM_SKIP_STATS_EN defined
//               Modports: slave (accumulator), master (operand source/sink).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adder_accum_12bit_if
    import adder_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,
    parameter int CNT_W = c_CNT_W
) ();

    logic             i_in_valid;
    logic             o_in_ready;
    logic [WIDTH-1:0] i_operand;
    logic             i_last;
    logic             o_out_valid;
    logic             i_out_ready;
    logic [WIDTH-1:0] o_sum;
    logic             o_ovf;
    logic [CNT_W-1:0] o_nops;
`ifdef ADDER_ACCUM_SKIP_STATS_EN
    logic [CNT_W-1:0] o_skip_hits;
`endif

    modport slave (
`ifdef ADDER_ACCUM_SKIP_STATS_EN
        output o_skip_hits,
`endif
        input  i_in_valid, i_operand, i_last, i_out_ready,
        output o_in_ready, o_out_valid, o_sum, o_ovf, o_nops
    );

    modport master (
`ifdef ADDER_ACCUM_SKIP_STATS_EN
        input  o_skip_hits,
`endif
        output i_in_valid, i_operand, i_last, i_out_ready,
        input  o_in_ready, o_out_valid, o_sum, o_ovf, o_nops
    );

endinterface

`default_nettype wire

// File: rtl/adder_accum_12bit_cskip_core.sv
// ============================================================================
// Module      : cskip_core
// Description : Combinational WIDTH-bit carry-skip adder. Carries ripple
//               inside each BLOCK-wide segment; when every bit of a segment
//               propagates, the segment's carry-in bypasses it directly.
//               a, b     - addends
//               cin      - carry in
//               sum      - WIDTH-bit result
//               cout     - carry out of the top block
//               blk_prop - per-block "all bits propagate" (skip taken)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cskip_core #(
    parameter int WIDTH = 12,
    parameter int BLOCK = 4
) (
    input  wire logic [WIDTH-1:0]       a,
    input  wire logic [WIDTH-1:0]       b,
    input  wire logic                   cin,
    output logic      [WIDTH-1:0]       sum,
    output logic                        cout,
    output logic      [WIDTH/BLOCK-1:0] blk_prop
);

    localparam int c_NBLK = WIDTH / BLOCK;

    logic w_carry;    // carry travelling up the chain
    logic w_blk_cin;  // carry entering the current block, kept for the skip mux
    logic w_p;

    // One sequential walk keeps the carry chain in a single process instead
    // of a self-referencing vector.
    always_comb begin
        sum       = '0;
        blk_prop  = '0;
        w_carry   = cin;
        w_blk_cin = 1'b0;
        w_p       = 1'b0;
        for (int i = 0; i < c_NBLK; i++) begin
            w_blk_cin   = w_carry;
            blk_prop[i] = &(a[i*BLOCK +: BLOCK] ^ b[i*BLOCK +: BLOCK]);
            for (int j = 0; j < BLOCK; j++) begin
                w_p                = a[i*BLOCK + j] ^ b[i*BLOCK + j];
                sum[i*BLOCK + j]   = w_p ^ w_carry;
                w_carry            = (a[i*BLOCK + j] & b[i*BLOCK + j]) | (w_p & w_carry);
            end
            // Fully propagating block: its carry-out equals its carry-in.
            if (blk_prop[i]) begin
                w_carry = w_blk_cin;
            end
        end
        cout = w_carry;
    end

endmodule

`default_nettype wire

// File: rtl/adder_accum_12bit.sv
// ============================================================================
// Module      : adder_accum_12bit
// Description : Accumulates a valid/ready operand stream through a carry-skip
//               adder. The operand flagged last closes the group; the total,
//               sticky carry-out flag and operand count are then held on the
//               result handshake until consumed.
//               i_clk   - rising-edge clock
//               i_rst_n - asynchronous active-low reset
//               i_clear - synchronous abort of the current group
//               bus     - adder_accum_12bit_if.slave operand/result bundle
//               Optional macro ADDER_ACCUM_SKIP_STATS_EN adds o_skip_hits, a
//               saturating count of operands that took at least one skip path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_accum_12bit
    import adder_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,
    parameter int BLOCK = c_BLOCK,
    parameter int CNT_W = c_CNT_W
) (
    input  wire logic           i_clk,
    input  wire logic           i_rst_n,
    input  wire logic           i_clear,
    adder_accum_12bit_if.slave  bus
);

    localparam int c_NB = WIDTH / BLOCK;

    acc_state_e       r_state;
    acc_state_e       w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic             r_ovf;
    logic [CNT_W-1:0] r_nops;
    logic             w_in_fire;
    logic             w_out_fire;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic [c_NB-1:0]  w_blk_prop;

    cskip_core #(
        .WIDTH (WIDTH),
        .BLOCK (BLOCK)
    ) u_cskip_core (
        .a        (r_acc),
        .b        (bus.i_operand),
        .cin      (1'b0),
        .sum      (w_sum),
        .cout     (w_cout),
        .blk_prop (w_blk_prop)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake qualification; clear overrides both handshakes.
    always_comb begin
        w_state_nxt = r_state;
        w_in_fire   = 1'b0;
        w_out_fire  = 1'b0;
        case (r_state)
            ACCUM: begin
                w_in_fire = bus.i_in_valid;
                if (bus.i_in_valid && bus.i_last) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                w_out_fire = bus.i_out_ready;
                if (bus.i_out_ready) begin
                    w_state_nxt = ACCUM;
                end
            end
            default: w_state_nxt = ACCUM;
        endcase
        if (i_clear) begin
            w_state_nxt = ACCUM;
            w_in_fire   = 1'b0;
            w_out_fire  = 1'b0;
        end
    end

    // Accumulator, sticky overflow and saturating operand count
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc  <= '0;
            r_ovf  <= 1'b0;
            r_nops <= '0;
        end else if (i_clear || w_out_fire) begin
            r_acc  <= '0;
            r_ovf  <= 1'b0;
            r_nops <= '0;
        end else if (w_in_fire) begin
            r_acc  <= w_sum;
            r_ovf  <= r_ovf | w_cout;
            if (r_nops != '1) begin
                r_nops <= r_nops + 1'b1;
            end
        end
    end

`ifdef ADDER_ACCUM_SKIP_STATS_EN
    logic [CNT_W-1:0] r_skip_hits;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_skip_hits <= '0;
        end else if (i_clear || w_out_fire) begin
            r_skip_hits <= '0;
        end else if (w_in_fire && (|w_blk_prop) && (r_skip_hits != '1)) begin
            r_skip_hits <= r_skip_hits + 1'b1;
        end
    end

    assign bus.o_skip_hits = r_skip_hits;
`else
    logic w_unused_blk_prop;
    assign w_unused_blk_prop = ^w_blk_prop;
`endif

    // Ready/valid depend on state only, so no path from i_out_ready to o_in_ready.
    assign bus.o_in_ready  = (r_state == ACCUM);
    assign bus.o_out_valid = (r_state == HOLD);
    assign bus.o_sum       = r_acc;
    assign bus.o_ovf       = r_ovf;
    assign bus.o_nops      = r_nops;

endmodule

`default_nettype wire
